// File: rtl/mem_access.sv
// mem_access: MEM stage, moves loads/stores byte-serially over the shared 8-bit RAM bus
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   aluop_i, rd_data_i, rd_addr_i,
//   mem_addr_i, rd_enable_i           EX/MEM fields (held stable while stall_req_o=1)
//   rd_data_o, rd_addr_o, rd_enable_o to MEM/WB
//   stall_req_o                       freezes the pipeline while an access is in flight
//   mem_req_o, mem_gnt_i              arbiter request / grant
//   mem_a_o, mem_wr_o, mem_dout_o     byte address, write strobe, write byte
//   mem_din_i                         read byte, RAM_LAT cycles after its address
//   misalign_o                        misaligned-access pulse
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned H/W accesses
// without touching the bus; otherwise they run byte-serially and misalign_o is 0.
`ifndef OpCodeLen
`define OpCodeLen 8
`define ADD 8'h10
`define LB  8'h01
`define LH  8'h02
`define LW  8'h03
`define LBU 8'h04
`define LHU 8'h05
`define SB  8'h06
`define SH  8'h07
`define SW  8'h08
`endif

module mem_access #(
    parameter int OP_W    = `OpCodeLen,
    parameter int RAM_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] aluop_i,
    input  logic [31:0]     rd_data_i,
    input  logic [4:0]      rd_addr_i,
    input  logic [31:0]     mem_addr_i,
    input  logic            rd_enable_i,
    output logic [31:0]     rd_data_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_enable_o,
    output logic            stall_req_o,
    output logic            mem_req_o,
    input  logic            mem_gnt_i,
    output logic [31:0]     mem_a_o,
    output logic            mem_wr_o,
    output logic [7:0]      mem_dout_o,
    input  logic [7:0]      mem_din_i,
    output logic            misalign_o
);
    localparam int PW = 2 * RAM_LAT;
    typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;
    state_t state, next, st;
    logic [15:0] cnt;
    logic [31:0] acc, ld_val;
    logic [RAM_LAT-1:0] pv;
    logic [PW-1:0] pk;
    logic is_load, is_store, is_mem, sgn, mis, last_x, last_d;
    logic [1:0] n_m1;

    assign is_load  = aluop_i inside {`LB, `LH, `LW, `LBU, `LHU};
    assign is_store = aluop_i inside {`SB, `SH, `SW};
    assign is_mem   = is_load | is_store;
    assign sgn      = aluop_i inside {`LB, `LH};
    assign n_m1     = (aluop_i inside {`LW, `SW}) ? 2'd3 : (aluop_i inside {`LH, `LHU, `SH}) ? 2'd1 : 2'd0;
`ifdef MEM_ALIGN_CHECK_EN
    assign mis = is_mem && ((n_m1 == 2'd1 && mem_addr_i[0]) || (n_m1 == 2'd3 && mem_addr_i[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif
    assign last_x = cnt == {14'd0, n_m1};
    assign last_d = cnt == 16'(RAM_LAT - 1);
    // Outputs see IDLE during reset so a mid-access reset stops bus writes at once.
    assign st     = rst ? IDLE : state;
    assign ld_val = n_m1 == 2'd0 ? {{24{sgn & acc[7]}}, acc[7:0]} :
                    n_m1 == 2'd1 ? {{16{sgn & acc[15]}}, acc[15:0]} : acc;

    always_ff @(posedge clk)
        state <= rst ? IDLE : next;

    always_comb begin
        next = IDLE;
        if (state == IDLE)
            next = !is_mem ? IDLE : mis ? DONE : mem_gnt_i ? XFER : IDLE;
        else if (state == XFER)
            next = !last_x ? XFER : is_load ? DRAIN : DONE;
        else if (state == DRAIN)
            next = last_d ? DONE : DRAIN;
    end

    // pv/pk carry each load byte's slot index until its data returns RAM_LAT cycles later.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            pv  <= '0;
            pk  <= '0;
            acc <= '0;
        end else begin
            cnt <= ((state == XFER && !last_x) || state == DRAIN) ? cnt + 16'd1 : 16'd0;
            pv  <= RAM_LAT'({pv, state == XFER && is_load});
            pk  <= PW'({pk, cnt[1:0]});
            if (state == IDLE)
                acc <= '0;
            else if (pv[RAM_LAT-1])
                acc[{pk[PW-1 -: 2], 3'b000} +: 8] <= mem_din_i;
        end
    end

    always_comb begin
        rd_addr_o   = rd_addr_i;
        rd_data_o   = (st == DONE && is_load) ? ld_val : rd_data_i;
        rd_enable_o = st == IDLE ? rd_enable_i & ~is_mem :
                      st == DONE ? rd_enable_i & is_load & ~mis : 1'b0;
        stall_req_o = !rst && (st == IDLE ? is_mem : st != DONE);
        mem_req_o   = !rst && (st == IDLE ? is_mem & ~mis : (st == XFER || st == DRAIN));
        mem_wr_o    = st == XFER && is_store;
        mem_a_o     = st == XFER ? mem_addr_i + {16'd0, cnt} : 32'd0;
        mem_dout_o  = (st == XFER && is_store) ? rd_data_i[{cnt[1:0], 3'b000} +: 8] : 8'd0;
        misalign_o  = st == DONE && mis;
    end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized and directed checks of mem_access against a byte-array reference model
`ifndef OpCodeLen
`define OpCodeLen 8
`define ADD 8'h10
`define LB  8'h01
`define LH  8'h02
`define LW  8'h03
`define LBU 8'h04
`define LHU 8'h05
`define SB  8'h06
`define SH  8'h07
`define SW  8'h08
`endif

module tb_mem_access;
    localparam int LAT = 1;
    logic clk = 1'b0, rst = 1'b1;
    logic [7:0] aluop_i = `ADD;
    logic [31:0] rd_data_i = '0, mem_addr_i = '0;
    logic [4:0] rd_addr_i = '0;
    logic rd_enable_i = 1'b0, mem_gnt_i = 1'b0;
    logic [7:0] mem_din_i;
    logic [31:0] rd_data_o, mem_a_o;
    logic [4:0] rd_addr_o;
    logic rd_enable_o, stall_req_o, mem_req_o, mem_wr_o, misalign_o;
    logic [7:0] mem_dout_o;
    logic [7:0] ram [1024];
    logic [7:0] mdl [1024];
    logic [39:0] wq [$];
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    mem_access #(.OP_W(8), .RAM_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .rd_data_i(rd_data_i), .rd_addr_i(rd_addr_i),
        .mem_addr_i(mem_addr_i), .rd_enable_i(rd_enable_i), .rd_data_o(rd_data_o),
        .rd_addr_o(rd_addr_o), .rd_enable_o(rd_enable_o), .stall_req_o(stall_req_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_a_o(mem_a_o), .mem_wr_o(mem_wr_o),
        .mem_dout_o(mem_dout_o), .mem_din_i(mem_din_i), .misalign_o(misalign_o)
    );

    // RAM device: one-cycle read latency, logs every write it receives.
    always @(posedge clk) begin
        if (mem_wr_o) begin
            wq.push_back({mem_a_o, mem_dout_o});
            ram[mem_a_o[9:0]] <= mem_dout_o;
        end
        mem_din_i <= ram[mem_a_o[9:0]];
    end

    function automatic int nbytes(input logic [7:0] op);
        return (op == `LW || op == `SW) ? 4 : (op == `LH || op == `LHU || op == `SH) ? 2 : 1;
    endfunction

    function automatic logic is_ld(input logic [7:0] op);
        return op == `LB || op == `LH || op == `LW || op == `LBU || op == `LHU;
    endfunction

    function automatic logic is_st(input logic [7:0] op);
        return op == `SB || op == `SH || op == `SW;
    endfunction

    function automatic logic exp_mis(input logic [7:0] op, input logic [31:0] addr);
`ifdef MEM_ALIGN_CHECK_EN
        return (nbytes(op) == 2 && addr % 2 != 0) || (nbytes(op) == 4 && addr % 4 != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_load(input logic [7:0] op, input logic [31:0] addr);
        logic [31:0] v = 0;
        for (int k = 0; k < nbytes(op); k++)
            v = v + (32'(mdl[(addr + k) % 1024]) << (8 * k));
        if (op == `LB && v >= 128) v = v - 32'd256;
        if (op == `LH && v >= 32768) v = v - 32'd65536;
        return v;
    endfunction

    task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] ra, input logic re, input int gdly,
                          output int stalls, output logic [31:0] rdo, output logic [4:0] rao,
                          output logic reo, output logic mis, output logic req_seen,
                          output logic done_ok);
        int w;
        @(posedge clk); #1;
        aluop_i = op; rd_data_i = data; rd_addr_i = ra; mem_addr_i = addr; rd_enable_i = re;
        mem_gnt_i = gdly == 0;
        wq.delete();
        w = 0; stalls = 0; done_ok = 0; req_seen = 0; rdo = '0; rao = '0; reo = 0; mis = 0;
        for (int c = 0; c < 40 && !done_ok; c++) begin
            @(negedge clk);
            req_seen |= mem_req_o;
            if (stall_req_o) begin
                stalls++;
                if (mem_req_o && !mem_gnt_i) w++;
                @(posedge clk); #1;
                mem_gnt_i = w >= gdly;
            end else begin
                done_ok = 1; rdo = rd_data_o; rao = rd_addr_o; reo = rd_enable_o; mis = misalign_o;
            end
        end
    endtask

    task automatic test_reset();
        aluop_i = `ADD; rd_data_i = 32'h1234; rd_addr_i = 5'd3; rd_enable_i = 1;
        @(negedge clk);
        vectors++;
        if ({stall_req_o, mem_req_o, mem_wr_o, misalign_o, mem_a_o, mem_dout_o} !== '0) begin
            miscompares++; $display("FAIL reset_bus: got %h want 0", {stall_req_o, mem_req_o, mem_wr_o, misalign_o, mem_a_o, mem_dout_o});
        end
        vectors++;
        if ({rd_data_o, rd_addr_o, rd_enable_o} !== {32'h1234, 5'd3, 1'b1}) begin
            miscompares++; $display("FAIL reset_pass: got %h/%h/%b want 1234/03/1", rd_data_o, rd_addr_o, rd_enable_o);
        end
        aluop_i = `LW;
        @(negedge clk);
        vectors++;
        if ({stall_req_o, mem_req_o} !== 2'b00) begin
            miscompares++; $display("FAIL reset_memop: got %b want 00", {stall_req_o, mem_req_o});
        end
        @(posedge clk); #1;
        aluop_i = `ADD; rst = 0;
    endtask

    task automatic test_passthrough();
        int st; logic [31:0] d; logic [4:0] a; logic e, m, rq, ok;
        run_op(`ADD, 32'h100, 32'h1234, 5'd7, 1'b1, 0, st, d, a, e, m, rq, ok);
        vectors++;
        if ({ok, st[7:0], rq} !== {1'b1, 8'd0, 1'b0}) begin
            miscompares++; $display("FAIL pass_stall: got ok=%b stall=%0d req=%b want 1/0/0", ok, st, rq);
        end
        vectors++;
        if ({d, a, e} !== {32'h1234, 5'd7, 1'b1}) begin
            miscompares++; $display("FAIL pass_data: got %h/%h/%b want 1234/07/1", d, a, e);
        end
    endtask

    task automatic test_load_word();
        int st; logic [31:0] d; logic [4:0] a; logic e, m, rq, ok;
        logic [7:0] b [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int k = 0; k < 4; k++) begin ram[256 + k] = b[k]; mdl[256 + k] = b[k]; end
        run_op(`LW, 32'h100, 32'h0, 5'd9, 1'b1, 0, st, d, a, e, m, rq, ok);
        vectors++;
        if (st != 6 || !ok) begin
            miscompares++; $display("FAIL lw_stall: got %0d want 6", st);
        end
        vectors++;
        if ({d, a, e} !== {32'hDEADBEEF, 5'd9, 1'b1}) begin
            miscompares++; $display("FAIL lw_data: got %h/%h/%b want deadbeef/09/1", d, a, e);
        end
        vectors++;
        if (wq.size() != 0) begin
            miscompares++; $display("FAIL lw_nowrite: got %0d writes want 0", wq.size());
        end
    endtask

    task automatic test_load_sign();
        int st; logic [31:0] d; logic [4:0] a; logic e, m, rq, ok;
        ram[7] = 8'h80; mdl[7] = 8'h80; ram[6] = 8'h00; mdl[6] = 8'h00;
        run_op(`LB, 32'h7, 32'h0, 5'd1, 1'b1, 0, st, d, a, e, m, rq, ok);
        vectors++;
        if (d !== 32'hFFFFFF80) begin
            miscompares++; $display("FAIL lb_sign: got %h want ffffff80", d);
        end
        run_op(`LBU, 32'h7, 32'h0, 5'd1, 1'b1, 0, st, d, a, e, m, rq, ok);
        vectors++;
        if (d !== 32'h00000080) begin
            miscompares++; $display("FAIL lbu_zero: got %h want 00000080", d);
        end
        run_op(`LH, 32'h6, 32'h0, 5'd1, 1'b1, 0, st, d, a, e, m, rq, ok);
        vectors++;
        if (d !== 32'hFFFF8000 || st != 4) begin
            miscompares++; $display("FAIL lh_sign: got %h stall %0d want ffff8000 stall 4", d, st);
        end
    endtask

    task automatic test_store_wait();
        int st; logic [31:0] d; logic [4:0] a; logic e, m, rq, ok;
        run_op(`SH, 32'h20, 32'hAABBCCDD, 5'd2, 1'b1, 3, st, d, a, e, m, rq, ok);
        mdl[32] = 8'hDD; mdl[33] = 8'hCC;
        vectors++;
        if (st != 6 || !ok) begin
            miscompares++; $display("FAIL sh_stall: got %0d want 6", st);
        end
        vectors++;
        if (wq.size() != 2 || wq[0] !== {32'h20, 8'hDD} || wq[1] !== {32'h21, 8'hCC}) begin
            miscompares++; $display("FAIL sh_writes: got %0d writes first %h want 2 writes 00000020dd,00000021cc", wq.size(), wq.size() > 0 ? wq[0] : 40'h0);
        end
        vectors++;
        if (e !== 1'b0) begin
            miscompares++; $display("FAIL sh_rden: got %b want 0", e);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        aluop_i = `SW; mem_addr_i = 32'h40; rd_data_i = 32'h11223344; rd_enable_i = 0; mem_gnt_i = 1;
        wq.delete();
        repeat (3) begin @(posedge clk); #1; end
        rst = 1; aluop_i = `ADD;
        @(negedge clk);
        vectors++;
        if ({stall_req_o, mem_req_o, mem_wr_o} !== 3'b000) begin
            miscompares++; $display("FAIL rstmid_during: got %b want 000", {stall_req_o, mem_req_o, mem_wr_o});
        end
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        vectors++;
        if ({stall_req_o, mem_req_o, mem_wr_o, mem_a_o, mem_dout_o} !== '0) begin
            miscompares++; $display("FAIL rstmid_after: got %h want 0", {stall_req_o, mem_req_o, mem_wr_o, mem_a_o, mem_dout_o});
        end
        mdl[64] = 8'h44; mdl[65] = 8'h33;
        vectors++;
        if (wq.size() != 2 || wq[0] !== {32'h40, 8'h44} || wq[1] !== {32'h41, 8'h33} || ram[66] !== mdl[66]) begin
            miscompares++; $display("FAIL rstmid_writes: got %0d writes want 2 (44@40, 33@41)", wq.size());
        end
    endtask

    task automatic test_misalign();
        int st; logic [31:0] d; logic [4:0] a; logic e, m, rq, ok;
        run_op(`LW, 32'h102, 32'h0, 5'd4, 1'b1, 0, st, d, a, e, m, rq, ok);
`ifdef MEM_ALIGN_CHECK_EN
        vectors++;
        if ({st[7:0], rq, m, e} !== {8'd1, 1'b0, 1'b1, 1'b0}) begin
            miscompares++; $display("FAIL misalign_chk: got stall=%0d req=%b mis=%b en=%b want 1/0/1/0", st, rq, m, e);
        end
`else
        vectors++;
        if ({st[7:0], m, e, d} !== {8'd6, 1'b0, 1'b1, exp_load(`LW, 32'h102)}) begin
            miscompares++; $display("FAIL misalign_ser: got stall=%0d mis=%b en=%b d=%h want 6/0/1/%h", st, m, e, d, exp_load(`LW, 32'h102));
        end
`endif
    endtask

    task automatic test_random();
        int st, n, es, gd; logic [31:0] d, ad, dat; logic [4:0] a, ra; logic e, m, rq, ok, re, mi;
        logic [7:0] op;
        logic [7:0] ops [10] = '{`ADD, `LB, `LH, `LW, `LBU, `LHU, `SB, `SH, `SW, 8'h20};
        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 9)];
            ad = $urandom_range(0, 1000); dat = $urandom; ra = 5'($urandom); re = 1'($urandom);
            gd = $urandom_range(0, 2);
            n = nbytes(op); mi = exp_mis(op, ad);
            es = !(is_ld(op) || is_st(op)) ? 0 : mi ? 1 : 1 + gd + n + (is_ld(op) ? LAT : 0);
            run_op(op, ad, dat, ra, re, gd, st, d, a, e, m, rq, ok);
            vectors++;
            if (!ok || st != es || rq !== ((is_ld(op) || is_st(op)) && !mi)) begin
                miscompares++; $display("FAIL rnd_stall[%0d] op %h: got stall=%0d req=%b want %0d", i, op, st, rq, es);
            end
            vectors++;
            if (a !== ra || m !== mi || e !== (is_st(op) || mi ? 1'b0 : re)) begin
                miscompares++; $display("FAIL rnd_ctl[%0d] op %h: got rd=%h mis=%b en=%b want %h/%b/%b", i, op, a, m, e, ra, mi, is_st(op) || mi ? 1'b0 : re);
            end
            if (!is_st(op) && !mi) begin
                vectors++;
                if (d !== (is_ld(op) ? exp_load(op, ad) : dat)) begin
                    miscompares++; $display("FAIL rnd_data[%0d] op %h: got %h want %h", i, op, d, is_ld(op) ? exp_load(op, ad) : dat);
                end
            end
            vectors++;
            if (wq.size() != (is_st(op) && !mi ? n : 0)) begin
                miscompares++; $display("FAIL rnd_wcount[%0d] op %h: got %0d want %0d", i, op, wq.size(), is_st(op) && !mi ? n : 0);
            end else if (is_st(op) && !mi) begin
                for (int k = 0; k < n; k++) begin
                    vectors++;
                    if (wq[k] !== {ad + 32'(k), 8'((dat >> (8 * k)) % 256)}) begin
                        miscompares++; $display("FAIL rnd_write[%0d.%0d]: got %h want %h", i, k, wq[k], {ad + 32'(k), 8'((dat >> (8 * k)) % 256)});
                    end
                    mdl[(ad + k) % 1024] = 8'((dat >> (8 * k)) % 256);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin ram[i] = 8'($urandom); mdl[i] = ram[i]; end
        test_reset();
        test_passthrough();
        test_load_word();
        test_load_sign();
        test_store_wait();
        test_reset_mid();
        test_misalign();
        test_random();
        @(posedge clk); #1;
        aluop_i = `ADD;
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
